// File: rtl/hc595_scan_sched.sv
// Digit-multiplex scheduler feeding a 16-bit 74HC595 shift driver from a CPU frame buffer.
// Words load once per driver frame (1-cycle S_EN at LOAD_OFS+1); no backpressure, the driver frame is fixed.
module hc595_scan_sched #(
    parameter int NUM_DIGITS   = 8,
    parameter int FRAME_CLKS   = 160,
    parameter int DWELL_FRAMES = 4,
    parameter int LOAD_OFS     = 157
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        en,
    input  logic        blank,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [15:0] Data,
    output logic        S_EN,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    localparam int FCW = $clog2(FRAME_CLKS);
    localparam int DCW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_CLKS - 1);
    localparam logic [FCW-1:0] LOAD_AT = FCW'(LOAD_OFS);
    localparam logic [DCW-1:0] DW_LAST = DCW'(DWELL_FRAMES - 1);
    localparam logic [2:0]     ND_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]     ND      = 4'(NUM_DIGITS);
    localparam logic [15:0]    IDLE_W  = 16'h00FF;

    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [DCW-1:0] dwell_q, dwell_d;
    logic [2:0]     scan_q, scan_d;
    logic [2:0]     digit_q, digit_d;
    logic [15:0]    data_q, data_d;
    logic           s_en_q, s_en_d;
    logic           fdone_q, fdone_d;
    logic [7:0]     rd_q, rd_d;
    logic [7:0]     buf_q [NUM_DIGITS];
    logic [7:0]     buf_d [NUM_DIGITS];

    logic           load;
    logic           wr_ok;
    logic [7:0]     cur_seg;

    // Frame phase counter; free-running so the load instant stays locked to the driver.
    always_comb begin
        frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + FCW'(1);
        load        = (frame_cnt_q == LOAD_AT);
        wr_ok       = wr_en && ({1'b0, wr_addr} < ND);
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            buf_d[i] = buf_q[i];
            if (wr_ok && (wr_addr == 3'(i))) begin
                buf_d[i] = wr_data;
            end
        end
    end

    // Read the old contents: a same-cycle write is not visible to readback.
    always_comb begin
        rd_d = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rd_addr == 3'(i)) begin
                rd_d = buf_q[i];
            end
        end
    end

    // Segment byte for the digit being loaded, with write-first bypass.
    always_comb begin
        cur_seg = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_q == 3'(i)) begin
                cur_seg = buf_q[i];
            end
        end
        if (wr_ok && (wr_addr == scan_q)) begin
            cur_seg = wr_data;
        end
    end

    always_comb begin
        data_d  = data_q;
        s_en_d  = 1'b0;
        digit_d = digit_q;
        fdone_d = 1'b0;
        scan_d  = scan_q;
        dwell_d = dwell_q;
        if (load) begin
            s_en_d = 1'b1;
            if (!en) begin
                data_d  = IDLE_W;
                digit_d = 3'd0;
                scan_d  = 3'd0;
                dwell_d = '0;
            end else begin
                data_d  = {(blank ? 8'h00 : cur_seg), ~(8'h01 << scan_q)};
                digit_d = scan_q;
                // Wrap is flagged on the first word of the new scan, not on a fresh start.
                fdone_d = (scan_q == 3'd0) && (dwell_q == '0) && (digit_q == ND_LAST);
                if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
                    scan_d  = (scan_q == ND_LAST) ? 3'd0 : scan_q + 3'd1;
                end else begin
                    dwell_d = dwell_q + DCW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            frame_cnt_q <= '0;
            dwell_q     <= '0;
            scan_q      <= 3'd0;
            digit_q     <= 3'd0;
            data_q      <= IDLE_W;
            s_en_q      <= 1'b0;
            fdone_q     <= 1'b0;
            rd_q        <= 8'h00;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            frame_cnt_q <= frame_cnt_d;
            dwell_q     <= dwell_d;
            scan_q      <= scan_d;
            digit_q     <= digit_d;
            data_q      <= data_d;
            s_en_q      <= s_en_d;
            fdone_q     <= fdone_d;
            rd_q        <= rd_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign Data       = data_q;
    assign S_EN       = s_en_q;
    assign digit_idx  = digit_q;
    assign frame_done = fdone_q;
    assign rd_data    = rd_q;

endmodule

// File: tb/tb_hc595_scan_sched.sv
// Directed bench for hc595_scan_sched: stimulus pushes expected load words, a monitor checks each S_EN.
module tb_hc595_scan_sched;

    logic        Clk;
    logic        Rst_n;
    logic        en, blank, wr_en;
    logic [2:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic [15:0] Data;
    logic        S_EN;
    logic [2:0]  digit_idx;
    logic        frame_done;

    logic        en4, blank4, wr_en4;
    logic [2:0]  wr_addr4, rd_addr4;
    logic [7:0]  wr_data4;
    logic [7:0]  rd_data4;
    logic [15:0] Data4;
    logic        S_EN4;
    logic [2:0]  digit_idx4;
    logic        frame_done4;

    hc595_scan_sched u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .en(en), .blank(blank),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .Data(Data), .S_EN(S_EN), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    hc595_scan_sched #(.NUM_DIGITS(4)) u_dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .en(en4), .blank(blank4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .rd_addr(rd_addr4), .rd_data(rd_data4),
        .Data(Data4), .S_EN(S_EN4), .digit_idx(digit_idx4), .frame_done(frame_done4)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        fd;
        logic [2:0]  di;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc;
    logic [15:0] last_data = 16'h00FF;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Cycles since reset release; the first load is expected in cycle 158 of each 160.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic fd, input logic [2:0] di);
        exp_t x;
        x.data = d;
        x.fd   = fd;
        x.di   = di;
        exp_q.push_back(x);
    endtask

    // Returns at the negedge inside the cycle whose rising edge performs the load.
    task automatic to_load();
        do @(negedge Clk); while ((cyc % 160) != 157);
    endtask

    function automatic logic [7:0] seg_of(input int k);
        return 8'((k + 1) * 17);
    endfunction

    function automatic logic [7:0] sel_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << k);
    endfunction

    always @(negedge Clk) begin
        if (!Rst_n) begin
            last_data = 16'h00FF;
        end else begin
            if (S_EN) begin
                chk("sen_phase", 32'(cyc % 160), 32'd158);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_sen: got Data=%h with empty queue", Data);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_data", Data, e.data);
                    chk("frame_done", frame_done, e.fd);
                    chk("digit_idx", digit_idx, e.di);
                end
            end else begin
                chk("data_hold", Data, last_data);
                chk("fd_without_sen", frame_done, 1'b0);
            end
            last_data = Data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0;
        en = 1'b0; blank = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; rd_addr = 3'd0;
        en4 = 1'b0; blank4 = 1'b0; wr_en4 = 1'b0; wr_addr4 = 3'd0; wr_data4 = 8'h00; rd_addr4 = 3'd0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;

        chk("rst_Data", Data, 16'h00FF);
        chk("rst_S_EN", S_EN, 1'b0);
        chk("rst_digit_idx", digit_idx, 3'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_Data4", Data4, 16'h00FF);

        // Narrow instance: address 7 is out of range and must not alias onto digit 3.
        @(negedge Clk); wr_en4 = 1'b1; wr_addr4 = 3'd3; wr_data4 = 8'h3C;
        @(negedge Clk); wr_addr4 = 3'd7; wr_data4 = 8'hC3;
        @(negedge Clk); wr_en4 = 1'b0; rd_addr4 = 3'd3;
        @(negedge Clk); chk("n4_rd3", rd_data4, 8'h3C); rd_addr4 = 3'd7;
        @(negedge Clk); chk("n4_rd7", rd_data4, 8'h00); rd_addr4 = 3'd3;
        @(negedge Clk); chk("n4_rd3_again", rd_data4, 8'h3C);

        // Idle loads with en low.
        to_load(); push(16'h00FF, 1'b0, 3'd0);
        to_load(); push(16'h00FF, 1'b0, 3'd0);

        for (int k = 0; k < 8; k++) begin
            @(negedge Clk); wr_en = 1'b1; wr_addr = 3'(k); wr_data = seg_of(k);
        end
        @(negedge Clk); wr_en = 1'b0; rd_addr = 3'd5;
        @(negedge Clk); chk("rd_buf5", rd_data, 8'h66);

        // First scan: no frame_done on a fresh start; en glitch between loads is ignored.
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < 4; d++) begin
                to_load();
                if (k == 0 && d == 0) en = 1'b1;
                push({seg_of(k), sel_of(k)}, 1'b0, 3'(k));
                if (k == 2 && d == 1) begin
                    repeat (5) @(negedge Clk);
                    en = 1'b0;
                    repeat (10) @(negedge Clk);
                    en = 1'b1;
                end
            end
        end

        for (int d = 0; d < 4; d++) begin
            to_load(); push(16'h11FE, (d == 0), 3'd0);
        end

        // Write-first bypass on the load cycle; readback sees the old value first.
        to_load();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hA5; rd_addr = 3'd1;
        push(16'hA5FD, 1'b0, 3'd1);
        @(negedge Clk); wr_en = 1'b0;
        chk("rd_old_on_write", rd_data, 8'h22);
        @(negedge Clk); chk("rd_new_after_write", rd_data, 8'hA5);
        for (int d = 1; d < 4; d++) begin
            to_load(); push(16'hA5FD, 1'b0, 3'd1);
        end

        for (int d = 0; d < 4; d++) begin
            to_load(); push(16'h33FB, 1'b0, 3'd2);
        end

        for (int d = 0; d < 4; d++) begin
            to_load();
            if (d == 0) blank = 1'b1;
            push(16'h00F7, 1'b0, 3'd3);
        end

        // Mid-dwell write to the displayed digit lands at its next load.
        to_load(); blank = 1'b0; push(16'h55EF, 1'b0, 3'd4);
        repeat (20) @(negedge Clk);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h5A;
        @(negedge Clk); wr_en = 1'b0;
        for (int d = 1; d < 4; d++) begin
            to_load(); push(16'h5AEF, 1'b0, 3'd4);
        end

        for (int d = 0; d < 2; d++) begin
            to_load(); push(16'h66DF, 1'b0, 3'd5);
        end
        for (int d = 0; d < 3; d++) begin
            to_load();
            if (d == 0) en = 1'b0;
            push(16'h00FF, 1'b0, 3'd0);
        end
        for (int d = 0; d < 4; d++) begin
            to_load();
            if (d == 0) en = 1'b1;
            push(16'h11FE, 1'b0, 3'd0);
        end
        for (int d = 0; d < 4; d++) begin
            to_load(); push(16'hA5FD, 1'b0, 3'd1);
        end

        // Asynchronous reset while S_EN is high.
        to_load();
        @(posedge Clk); #1;
        chk("sen_before_reset", S_EN, 1'b1);
        #1 Rst_n = 1'b0;
        #1;
        chk("arst_S_EN", S_EN, 1'b0);
        chk("arst_Data", Data, 16'h00FF);
        chk("arst_digit_idx", digit_idx, 3'd0);
        chk("arst_frame_done", frame_done, 1'b0);
        en = 1'b0; rd_addr = 3'd0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk); chk("cleared_buf0", rd_data, 8'h00); rd_addr = 3'd4;
        @(negedge Clk); chk("cleared_buf4", rd_data, 8'h00);

        to_load(); push(16'h00FF, 1'b0, 3'd0);
        to_load(); en = 1'b1; push(16'h00FE, 1'b0, 3'd0);

        repeat (4) @(negedge Clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("n4_idle_Data", Data4, 16'h00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
